// File: rtl/loop_seq_checker_if.sv
// Step-stream bus between a nested-loop generator (master) and loop_seq_checker (slave).
interface loop_seq_checker_if;
  logic       s_valid;
  logic [7:0] s_act1;
  logic [7:0] s_act2;
  logic [7:0] x_idx;
  logic [7:0] y_idx;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output s_valid, s_act1, s_act2,
    input  x_idx, y_idx, busy, done, err, err_cnt
  );

  modport slave (
    input  s_valid, s_act1, s_act2,
    output x_idx, y_idx, busy, done, err, err_cnt
  );
endinterface

// File: rtl/loop_seq_checker.sv
// Checks a flattened nested-loop (act1, act2) step stream against the expected schedule.
// Optional LOOP_CHK_STICKY_ERR_EN: first mismatch locks the checker in an error state until reset.
module loop_seq_checker #(
  parameter int unsigned OUTER = 10,
  parameter int unsigned INNER = 10
) (
  input logic               clk,
  input logic               rst,
  loop_seq_checker_if.slave bus
);
  localparam logic [7:0] OuterLast = 8'(OUTER - 1);
  localparam logic [7:0] InnerLast = 8'(INNER - 1);

  typedef enum logic [1:0] {StOstep, StIstep, StWrap, StErr} state_e;

  state_e     state_q, state_d;
  logic [7:0] exp1_q, exp1_d;
  logic [7:0] exp2_q, exp2_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       mismatch;

  always_comb begin
    state_d  = state_q;
    exp1_d   = exp1_q;
    exp2_d   = exp2_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mismatch = 1'b0;
`ifdef LOOP_CHK_STICKY_ERR_EN
    err_d    = err_q;
`else
    err_d    = 1'b0;
`endif

    unique case (state_q)
      StOstep: begin
        if (bus.s_valid) begin
          mismatch = (bus.s_act2 != exp2_q + 8'd1) || (bus.s_act1 != exp1_q);
          exp2_d   = exp2_q + 8'd1;
          y_d      = 8'd0;
          busy_d   = 1'b1;
          state_d  = StIstep;
        end
      end
      StIstep: begin
        if (bus.s_valid) begin
          mismatch = (bus.s_act1 != exp2_q) || (bus.s_act2 != exp2_q);
          exp1_d   = exp2_q;
          busy_d   = 1'b1;
          if (y_q == InnerLast) begin
            y_d = 8'd0;
            if (x_q == OuterLast) begin
              state_d = StWrap;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              x_d     = x_q + 8'd1;
              state_d = StOstep;
            end
          end else begin
            y_d = y_q + 8'd1;
          end
        end
      end
      // Matches the generator's clear cycle; any sample presented here is dropped.
      StWrap: begin
        x_d     = 8'd0;
        y_d     = 8'd0;
        exp1_d  = 8'd0;
        exp2_d  = 8'd0;
        state_d = StOstep;
      end
      default: ;
    endcase

    if (mismatch) begin
      err_d = 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`ifdef LOOP_CHK_STICKY_ERR_EN
      state_d = StErr;
      busy_d  = 1'b1;
      done_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOstep;
      exp1_q  <= 8'd0;
      exp2_q  <= 8'd0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp1_q  <= exp1_d;
      exp2_q  <= exp2_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.x_idx   = x_q;
  assign bus.y_idx   = y_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = cnt_q;
endmodule
